data_memory_sync: RTL

DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

---
 rtl/data_memory_sync.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/data_memory_sync.sv
// rtl/data_memory_sync.sv - word-addressed data memory with single and two-beat double-word accesses
module data_memory_sync #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4096
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_req,
    input  logic                      i_write,
    input  logic                      i_double,
    input  logic [ADDR_WIDTH-1:0]     i_address,
    input  logic [2*DATA_WIDTH-1:0]   i_write_data,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [2*DATA_WIDTH-1:0]   o_read_data,
    output logic                      o_fault
);

    localparam int                  IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT2 = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic [DATA_WIDTH-1:0]    r_mem [0:DEPTH-1];

    // Latched context of a double access carried into its second beat
    logic [IDX_W-1:0]         r_idx;
    logic [DATA_WIDTH-1:0]    r_data_lo;
    logic [DATA_WIDTH-1:0]    r_read_hi;
    logic                     r_write;
    logic                     r_pend_fault;

    logic                     r_valid;
    logic                     r_fault;
    logic [2*DATA_WIDTH-1:0]  r_read_data;

    logic [ADDR_WIDTH:0]      w_addr_ext;
    logic [ADDR_WIDTH:0]      w_addr_ext_p1;
    logic                     w_req_fault;
    logic                     w_accept;
    logic [IDX_W-1:0]         w_idx_p1;
    logic [IDX_W-1:0]         w_mem_idx;
    logic                     w_mem_we;
    logic [DATA_WIDTH-1:0]    w_mem_wdata;
    logic [DATA_WIDTH-1:0]    w_rd_word;

    // Range check is done one bit wider than the address so A+1 never wraps
    assign w_addr_ext    = {1'b0, i_address};
    assign w_addr_ext_p1 = w_addr_ext + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_req_fault   = (w_addr_ext >= DEPTH_EXT) |
                           (i_double & (w_addr_ext_p1 >= DEPTH_EXT));
    assign w_accept      = i_reset_n & i_req & (r_state == IDLE);
    assign w_idx_p1      = r_idx + IDX_ONE;
    assign w_rd_word     = r_mem[w_mem_idx];

    assign o_busy      = (r_state == BEAT2);
    assign o_valid     = r_valid;
    assign o_fault     = r_fault;
    assign o_read_data = r_read_data;

    // State register; reset returns to IDLE, aborting any pending second beat
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and memory port control; writes are suppressed by faults and reset
    always_comb begin
        w_next_state = r_state;
        w_mem_idx    = i_address[IDX_W-1:0];
        w_mem_we     = 1'b0;
        w_mem_wdata  = i_write_data[DATA_WIDTH-1:0];
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_mem_we = i_write & ~w_req_fault;
                    if (i_double) begin
                        w_next_state = BEAT2;
                        w_mem_wdata  = i_write_data[2*DATA_WIDTH-1:DATA_WIDTH];
                    end
                end
            end
            BEAT2: begin
                w_next_state = IDLE;
                w_mem_idx    = w_idx_p1;
                w_mem_wdata  = r_data_lo;
                w_mem_we     = i_reset_n & r_write & ~r_pend_fault;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Storage: no reset, so contents survive i_reset_n
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // Completion pulse, fault flag, read result and double-access context
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_valid      <= 1'b0;
            r_fault      <= 1'b0;
            r_read_data  <= '0;
            r_idx        <= '0;
            r_data_lo    <= '0;
            r_read_hi    <= '0;
            r_write      <= 1'b0;
            r_pend_fault <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            if (r_state == BEAT2) begin
                r_valid <= 1'b1;
                r_fault <= r_pend_fault;
                if (!r_write) begin
                    r_read_data <= r_pend_fault ? '0 : {r_read_hi, w_rd_word};
                end
            end else if (w_accept) begin
                if (i_double) begin
                    r_idx        <= i_address[IDX_W-1:0];
                    r_data_lo    <= i_write_data[DATA_WIDTH-1:0];
                    r_read_hi    <= w_rd_word;
                    r_write      <= i_write;
                    r_pend_fault <= w_req_fault;
                end else begin
                    r_valid <= 1'b1;
                    r_fault <= w_req_fault;
                    if (!i_write) begin
                        r_read_data <= w_req_fault ? '0 : {{DATA_WIDTH{1'b0}}, w_rd_word};
                    end
                end
            end
        end
    end

endmodule
